max_pool2d: RTL and testbench
=============================

Name: max_pool2d

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the 3x3 FP32 convolution stage.
- Consumes the conv output stream (IEEE-754 single, raster order, WIDTH x WIDTH per frame) using its valid strobe.
- Emits a (WIDTH/2) x (WIDTH/2) pooled map in raster order.
- Optional ReLU clamp on the output; feeds the next conv/line-buffer stage or the classifier.

Parameters:
- DATA_WIDTH, 32, sample width; fixed FP32 format, other values unsupported.
- WIDTH, 5, input feature-map side length in pixels; must be >= 2 and <= 254.
- RELU_EN, 0, when 1, outputs with sign bit set are replaced by 32'h00000000.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous and active-low.
- valid_in  input  1  data_in holds a valid conv output this cycle.
- data_in  input  DATA_WIDTH  FP32 input pixel.
- valid_out  output  1  one-cycle strobe; data_out is a pooled result.
- data_out  output  DATA_WIDTH  FP32 pooled pixel.
- frame_done  output  1  one-cycle strobe coincident with the last pooled output of a frame.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While rst=0:
  - col=0, row=0, hold register and partial buffer cleared to 0.
  - valid_out=0, data_out=0, frame_done=0.
- Counters: col (0..WIDTH-1), row (0..WIDTH-1).
  - Both advance only on valid_in=1; gaps (valid_in=0) freeze all state.
  - col wraps to 0 after WIDTH-1 and increments row.
  - row wraps to 0 after the last pixel of row WIDTH-1, which ends the frame.
- Odd WIDTH: pixels with col==WIDTH-1 or row==WIDTH-1 (odd index) are consumed and ignored (floor pooling). Output map side is P=WIDTH/2, truncated.
- Pair stage:
  - Even col: data_in is latched into hold.
  - Odd col: hmax = fmax(hold, data_in).
- Partial buffer: P entries of DATA_WIDTH, indexed by col>>1.
  - Even row, odd col: buf[col>>1] <= hmax.
  - Odd row, odd col: result = fmax(buf[col>>1], hmax). On the next cycle, valid_out=1 and data_out=result (after optional ReLU).
- Latency: exactly 1 clock from the valid_in cycle that carries the bottom-right pixel of a window to the valid_out cycle.
  - valid_out is never asserted two cycles in a row.
  - data_out holds its last value when valid_out=0.
- frame_done: asserted with the valid_out for window (P-1, P-1).
- fmax(a,b) comparison rules:
  - Both sign=0: larger unsigned magnitude wins.
  - Both sign=1: smaller unsigned magnitude wins.
  - Mixed signs: the sign=0 operand wins.
  - +0 vs -0: +0 wins.
  - Equal bit patterns: first operand.
  - No NaN/Inf special handling; operands are compared by the above rules on raw bits.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle immediately after the last pixel of frame N. No bubble is required.
- Reset mid-frame: partial state is discarded. The first valid_in after reset release is treated as pixel (0,0). No output is produced for the interrupted frame.
- No backpressure: the consumer must accept every valid_out strobe.

Test Plan:
- WIDTH=4, RELU_EN=0, input 1.0..16.0 raster (3F800000..41800000), valid_in continuous -> valid_out 4 times with 40C00000 (6.0), 41000000 (8.0), 41600000 (14.0), 41800000 (16.0); frame_done with the last output; each output 1 cycle after pixels 6, 8, 14, 16.
- WIDTH=4, all pixels negative: window 0 = {-1.0 BF800000, -2.0 C0000000, -3.0, -4.0} -> data_out BF800000. With RELU_EN=1 -> 00000000.
- Window {80000000 (-0), 00000000 (+0), -1.0, -2.0} -> data_out 00000000. Window with equal values 3F800000 x4 -> 3F800000.
- WIDTH=5, input 1.0..25.0 -> exactly 4 outputs: 7.0 (40E00000), 9.0 (41100000), 17.0 (41880000), 19.0 (41980000). Column 4 and row 4 are ignored; frame_done with 19.0; next frame's first pixel is accepted as (0,0).
- WIDTH=4, random 1-3 cycle gaps between valid_in pulses -> same outputs as the continuous case. Each output still occurs exactly 1 cycle after its completing pixel; no spurious valid_out during gaps.
- WIDTH=4, assert rst=0 asynchronously after pixel 7 of frame 1 (mid-clock) -> outputs clear immediately; after release, a full 1.0..16.0 frame yields 6.0, 8.0, 14.0, 16.0 with no stale output.

Source files
------------

// File: rtl/max_pool2d.sv
// Streaming 2x2 stride-2 max pooling over a raster FP32 feature map.
// Odd trailing rows/columns are consumed but never pooled (floor pooling).
module max_pool2d #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int RELU_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int P  = WIDTH / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam logic [7:0] LAST = 8'(WIDTH - 1);
  localparam logic [7:0] SPAN = 8'(2 * P);
  localparam logic [6:0] LASTWIN = 7'(P - 1);

  logic [7:0]            r_col;
  logic [7:0]            r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_buf [P];
  logic                  r_validOut;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic                  r_frameDone;

  logic [IW-1:0]         w_idx;
  logic                  w_inPool;
  logic                  w_emit;
  logic                  w_lastWin;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_relu;

  // Raw-bit FP32 max: positive beats negative, +0 beats -0, ties keep a.
  function automatic logic [DATA_WIDTH-1:0] fMax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] res;
    if (a == b) begin
      res = a;
    end else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      res = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      res = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    end else begin
      res = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
    end
    return res;
  endfunction

  assign w_idx     = r_col[IW:1];
  assign w_inPool  = (r_col < SPAN) && (r_row < SPAN);
  assign w_emit    = valid_in && w_inPool && r_col[0] && r_row[0];
  assign w_lastWin = (r_col[7:1] == LASTWIN) && (r_row[7:1] == LASTWIN);
  assign w_hmax    = fMax(r_hold, data_in);
  assign w_result  = fMax(r_buf[w_idx], w_hmax);
  assign w_relu    = ((RELU_EN != 0) && w_result[DATA_WIDTH-1]) ? '0 : w_result;

  // Raster position of the pixel currently on data_in; frozen during gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? 8'd0 : r_row + 8'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // Horizontal pair hold and the top-row partial maxima for each window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      for (int i = 0; i < P; i++) begin
        r_buf[i] <= '0;
      end
    end else if (valid_in && w_inPool) begin
      if (!r_col[0]) begin
        r_hold <= data_in;
      end else if (!r_row[0]) begin
        r_buf[w_idx] <= w_hmax;
      end
    end
  end

  // Register the finished window one cycle after its bottom-right pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validOut  <= 1'b0;
      r_dataOut   <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_validOut  <= w_emit;
      r_frameDone <= w_emit && w_lastWin;
      if (w_emit) begin
        r_dataOut <= w_relu;
      end
    end
  end

  assign valid_out  = r_validOut;
  assign data_out   = r_dataOut;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_max_pool2d.sv
// Directed bench for max_pool2d: three instances (WIDTH=4, WIDTH=4 with ReLU,
// WIDTH=5) checked with immediate assertions against hand-computed values.
module tb_max_pool2d;

  logic        clk;
  logic        rst;
  logic        v4;
  logic [31:0] d4;
  logic        v5;
  logic [31:0] d5;

  logic        validA, doneA;
  logic [31:0] dataA;
  logic        validB, doneB;
  logic [31:0] dataB;
  logic        validC, doneC;
  logic [31:0] dataC;

  int compared;
  int mismatched;

  logic [31:0] pix [16];
  logic [31:0] expA [4];
  logic [31:0] expB [4];

  max_pool2d #(.DATA_WIDTH(32), .WIDTH(4), .RELU_EN(0)) dutA (
    .clk(clk), .rst(rst), .valid_in(v4), .data_in(d4),
    .valid_out(validA), .data_out(dataA), .frame_done(doneA)
  );

  max_pool2d #(.DATA_WIDTH(32), .WIDTH(4), .RELU_EN(1)) dutB (
    .clk(clk), .rst(rst), .valid_in(v4), .data_in(d4),
    .valid_out(validB), .data_out(dataB), .frame_done(doneB)
  );

  max_pool2d #(.DATA_WIDTH(32), .WIDTH(5), .RELU_EN(0)) dutC (
    .clk(clk), .rst(rst), .valid_in(v5), .data_in(d5),
    .valid_out(validC), .data_out(dataC), .frame_done(doneC)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small positive integer to FP32 bit pattern, used only to build inputs.
  function automatic logic [31:0] toFloat(input int n);
    logic [7:0]  nb;
    logic [31:0] m;
    int          e;
    nb = 8'(n);
    e  = 0;
    for (int i = 0; i < 8; i++) begin
      if (nb[i]) e = i;
    end
    m = 32'(nb) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // One comparison: count it, and report a FAIL line when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one pixel for one clock, then return #1 after the capturing edge.
  task automatic applyStimulus(input logic sel5, input logic [31:0] pixel);
    if (sel5) begin
      v5 = 1'b1;
      d5 = pixel;
    end else begin
      v4 = 1'b1;
      d4 = pixel;
    end
    @(posedge clk);
    #1;
    v4 = 1'b0;
    v5 = 1'b0;
  endtask

  // Stream one WIDTH=4 frame into dutA/dutB with up to maxGap idle cycles per pixel.
  task automatic runFrame4(input string tag, input int maxGap);
    int w;
    int gap;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, pix[k-1]);
      case (k)
        6:       w = 0;
        8:       w = 1;
        14:      w = 2;
        16:      w = 3;
        default: w = -1;
      endcase
      if (w >= 0) begin
        checkOutput($sformatf("%s_vA_k%0d", tag, k), {31'b0, validA}, 32'd1);
        checkOutput($sformatf("%s_dA_k%0d", tag, k), dataA, expA[w]);
        checkOutput($sformatf("%s_dB_k%0d", tag, k), dataB, expB[w]);
        checkOutput($sformatf("%s_fd_k%0d", tag, k), {31'b0, doneA}, {31'b0, (w == 3)});
      end else begin
        checkOutput($sformatf("%s_vA_k%0d", tag, k), {31'b0, validA}, 32'd0);
        checkOutput($sformatf("%s_vB_k%0d", tag, k), {31'b0, validB}, 32'd0);
      end
      if (maxGap > 0) begin
        gap = $urandom_range(1, maxGap);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          checkOutput($sformatf("%s_gap_k%0d", tag, k), {31'b0, validA}, 32'd0);
        end
      end
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    v4  = 1'b0;
    d4  = '0;
    v5  = 1'b0;
    d5  = '0;

    @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, validA}, 32'd0);
    checkOutput("rst_data", dataA, 32'h0);
    checkOutput("rst_done", {31'b0, doneA}, 32'd0);
    rst = 1'b1;

    $display("[TB] continuous 1..16 frame");
    for (int k = 0; k < 16; k++) pix[k] = toFloat(k + 1);
    expA = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    expB = expA;
    runFrame4("seq", 0);

    $display("[TB] all-negative frame");
    for (int k = 0; k < 16; k++) pix[k] = 32'hC0A00000;
    pix[0] = 32'hBF800000;
    pix[1] = 32'hC0000000;
    pix[4] = 32'hC0400000;
    pix[5] = 32'hC0800000;
    expA = '{32'hBF800000, 32'hC0A00000, 32'hC0A00000, 32'hC0A00000};
    expB = '{32'h0, 32'h0, 32'h0, 32'h0};
    runFrame4("neg", 0);

    $display("[TB] signed zero and equal-value windows");
    for (int k = 0; k < 16; k++) pix[k] = 32'h40400000;
    pix[0] = 32'h80000000;
    pix[1] = 32'h00000000;
    pix[4] = 32'hBF800000;
    pix[5] = 32'hC0000000;
    pix[2] = 32'h3F800000;
    pix[3] = 32'h3F800000;
    pix[6] = 32'h3F800000;
    pix[7] = 32'h3F800000;
    expA = '{32'h00000000, 32'h3F800000, 32'h40400000, 32'h40400000};
    expB = expA;
    runFrame4("zero", 0);

    $display("[TB] gapped 1..16 frame");
    for (int k = 0; k < 16; k++) pix[k] = toFloat(k + 1);
    expA = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    expB = expA;
    runFrame4("gap", 3);

    $display("[TB] WIDTH=5 frame 1..25 then next frame");
    for (int k = 1; k <= 25; k++) begin
      applyStimulus(1'b1, toFloat(k));
      case (k)
        7: begin
          checkOutput("w5_v7", {31'b0, validC}, 32'd1);
          checkOutput("w5_d7", dataC, 32'h40E00000);
          checkOutput("w5_fd7", {31'b0, doneC}, 32'd0);
        end
        9: begin
          checkOutput("w5_v9", {31'b0, validC}, 32'd1);
          checkOutput("w5_d9", dataC, 32'h41100000);
        end
        17: begin
          checkOutput("w5_v17", {31'b0, validC}, 32'd1);
          checkOutput("w5_d17", dataC, 32'h41880000);
        end
        19: begin
          checkOutput("w5_v19", {31'b0, validC}, 32'd1);
          checkOutput("w5_d19", dataC, 32'h41980000);
          checkOutput("w5_fd19", {31'b0, doneC}, 32'd1);
        end
        default: checkOutput($sformatf("w5_idle_k%0d", k), {31'b0, validC}, 32'd0);
      endcase
    end
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, toFloat(40 - k));
      if (k == 7) begin
        checkOutput("w5n_v7", {31'b0, validC}, 32'd1);
        checkOutput("w5n_d7", dataC, 32'h421C0000);
        checkOutput("w5n_fd7", {31'b0, doneC}, 32'd0);
      end else begin
        checkOutput($sformatf("w5n_idle_k%0d", k), {31'b0, validC}, 32'd0);
      end
    end

    $display("[TB] asynchronous reset mid-frame");
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, toFloat(k));
    end
    checkOutput("mid_hold_v", {31'b0, validA}, 32'd0);
    checkOutput("mid_hold_d", dataA, 32'h40C00000);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_v", {31'b0, validA}, 32'd0);
    checkOutput("mid_rst_d", dataA, 32'h0);
    checkOutput("mid_rst_fd", {31'b0, doneA}, 32'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) pix[k] = toFloat(k + 1);
    expA = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    expB = expA;
    runFrame4("post", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
